// File: rtl/sap1_pkg.sv
// SAP-1 controller-sequencer shared definitions: opcodes, T-state ring indices
// and the 12-bit control word layout.
package sap1_pkg;

  localparam logic [3:0] OP_LDA = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_OUT = 4'b1110;
  localparam logic [3:0] OP_HLT = 4'b1111;

  // Bit positions of each T-state inside the one-hot ring.
  localparam int unsigned T1 = 0;
  localparam int unsigned T2 = 1;
  localparam int unsigned T3 = 2;
  localparam int unsigned T4 = 3;
  localparam int unsigned T5 = 4;
  localparam int unsigned T6 = 5;

  typedef struct packed {
    logic cp;
    logic ep;
    logic lm_bar;
    logic ce_bar;
    logic li_bar;
    logic ei_bar;
    logic la_bar;
    logic ea;
    logic su;
    logic eu;
    logic lb_bar;
    logic lo_bar;
  } ctrl_word_t;

  localparam ctrl_word_t CW_NOP = '{
    cp:     1'b0,
    ep:     1'b0,
    lm_bar: 1'b1,
    ce_bar: 1'b1,
    li_bar: 1'b1,
    ei_bar: 1'b1,
    la_bar: 1'b1,
    ea:     1'b0,
    su:     1'b0,
    eu:     1'b0,
    lb_bar: 1'b1,
    lo_bar: 1'b1
  };

endpackage

// File: rtl/sap1_controller_sequencer_if.sv
// Opcode in, control word / halt / T-state out between the sequencer and the
// SAP-1 datapath.
interface sap1_controller_sequencer_if #(
  parameter int OPCODE_W = 4,
  parameter int RING_W   = 6
);

  logic [OPCODE_W-1:0] opcode;
  logic                Cp;
  logic                Ep;
  logic                Lm_bar;
  logic                CE_bar;
  logic                Li_bar;
  logic                Ei_bar;
  logic                La_bar;
  logic                Ea;
  logic                Su;
  logic                Eu;
  logic                Lb_bar;
  logic                Lo_bar;
  logic                hlt;
  logic [RING_W-1:0]   t_state;

  modport master (
    input  opcode,
    output Cp, Ep, Lm_bar, CE_bar, Li_bar, Ei_bar, La_bar,
    output Ea, Su, Eu, Lb_bar, Lo_bar, hlt, t_state
  );

  modport slave (
    output opcode,
    input  Cp, Ep, Lm_bar, CE_bar, Li_bar, Ei_bar, La_bar,
    input  Ea, Su, Eu, Lb_bar, Lo_bar, hlt, t_state
  );

endinterface

// File: rtl/sap1_ring_counter.sv
// One-hot T-state ring: rotates T1..T6, freezes on hold, and falls back to T1
// from any value that is not exactly one-hot.
module sap1_ring_counter #(
  parameter int RING_W = 6
) (
  input  logic              CLK,
  input  logic              CLR,
  input  logic              hold,
  output logic [RING_W-1:0] t_state
);

  localparam logic [RING_W-1:0] RING_T1 = RING_W'(1);

  logic [RING_W-1:0] ring;

  always_ff @(posedge CLK) begin
    if (CLR) begin
      ring <= RING_T1;
    end else if (!$onehot(ring)) begin
      ring <= RING_T1;
    end else if (hold) begin
      ring <= ring;
    end else begin
      ring <= {ring[RING_W-2:0], ring[RING_W-1]};
    end
  end

  assign t_state = ring;

endmodule

// File: rtl/sap1_controller_sequencer.sv
// SAP-1 controller-sequencer: owns the halt flag and decodes the control word
// from the T-state ring and opcode.
module sap1_controller_sequencer
  import sap1_pkg::*;
#(
  parameter int OPCODE_W = 4,
  parameter int RING_W   = 6
) (
  input logic                          CLK,
  input logic                          CLR,
  sap1_controller_sequencer_if.master  bus
);

  localparam logic [RING_W-1:0] RING_T3 = RING_W'(1) << T3;

  logic [RING_W-1:0] ring;
  logic              halted;
  ctrl_word_t        cw;

  sap1_ring_counter #(
    .RING_W (RING_W)
  ) u_ring (
    .CLK     (CLK),
    .CLR     (CLR),
    .hold    (halted),
    .t_state (ring)
  );

  // Halt is taken on the T3->T4 edge so the ring lands in T4 and freezes there.
  always_ff @(posedge CLK) begin
    if (CLR) begin
      halted <= 1'b0;
    end else if (!halted && (ring == RING_T3) && (bus.opcode == OP_HLT)) begin
      halted <= 1'b1;
    end
  end

  always_comb begin
    cw = CW_NOP;
    if (!CLR && !halted && $onehot(ring)) begin
      if (ring[T1]) begin
        cw.ep     = 1'b1;
        cw.lm_bar = 1'b0;
      end else if (ring[T2]) begin
        cw.cp = 1'b1;
      end else if (ring[T3]) begin
        cw.ce_bar = 1'b0;
        cw.li_bar = 1'b0;
      end else if (ring[T4]) begin
        case (bus.opcode)
          OP_LDA, OP_ADD, OP_SUB: begin
            cw.ei_bar = 1'b0;
            cw.lm_bar = 1'b0;
          end
          OP_OUT: begin
            cw.ea     = 1'b1;
            cw.lo_bar = 1'b0;
          end
          default: cw = CW_NOP;
        endcase
      end else if (ring[T5]) begin
        case (bus.opcode)
          OP_LDA: begin
            cw.ce_bar = 1'b0;
            cw.la_bar = 1'b0;
          end
          OP_ADD: begin
            cw.ce_bar = 1'b0;
            cw.lb_bar = 1'b0;
          end
          OP_SUB: begin
            cw.ce_bar = 1'b0;
            cw.lb_bar = 1'b0;
            cw.su     = 1'b1;
          end
          default: cw = CW_NOP;
        endcase
      end else if (ring[T6]) begin
        case (bus.opcode)
          OP_ADD: begin
            cw.eu     = 1'b1;
            cw.la_bar = 1'b0;
          end
          OP_SUB: begin
            cw.eu     = 1'b1;
            cw.la_bar = 1'b0;
            cw.su     = 1'b1;
          end
          default: cw = CW_NOP;
        endcase
      end
    end
  end

  assign bus.Cp      = cw.cp;
  assign bus.Ep      = cw.ep;
  assign bus.Lm_bar  = cw.lm_bar;
  assign bus.CE_bar  = cw.ce_bar;
  assign bus.Li_bar  = cw.li_bar;
  assign bus.Ei_bar  = cw.ei_bar;
  assign bus.La_bar  = cw.la_bar;
  assign bus.Ea      = cw.ea;
  assign bus.Su      = cw.su;
  assign bus.Eu      = cw.eu;
  assign bus.Lb_bar  = cw.lb_bar;
  assign bus.Lo_bar  = cw.lo_bar;
  assign bus.hlt     = halted & ~CLR;
  assign bus.t_state = ring;

  // At most one W-bus driver per cycle.
  a_bus_conflict: assert property (@(posedge CLK)
    $onehot0({bus.Ep, ~bus.CE_bar, ~bus.Ei_bar, bus.Ea, bus.Eu}));

endmodule

// File: tb/tb_sap1_controller_sequencer.sv
// Randomized self-checking bench for the SAP-1 controller-sequencer against a
// step-counter / microcode-table reference model.
module tb_sap1_controller_sequencer;

  logic clk;
  logic clr;
  int   n_cmp;
  int   n_fail;

  // Reference model: instruction step 0..5 and halt flag.
  int   m_step;
  bit   m_halted;

  sap1_controller_sequencer_if #(.OPCODE_W(4), .RING_W(6)) bus ();

  sap1_controller_sequencer #(
    .OPCODE_W (4),
    .RING_W   (6)
  ) dut (
    .CLK (clk),
    .CLR (clr),
    .bus (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Normalized active-high view: {hlt, Cp, Ep, Lm, CE, Li, Ei, La, Ea, Su, Eu, Lb, Lo, t_state}
  function automatic logic [18:0] obs();
    return {bus.hlt, bus.Cp, bus.Ep, ~bus.Lm_bar, ~bus.CE_bar, ~bus.Li_bar,
            ~bus.Ei_bar, ~bus.La_bar, bus.Ea, bus.Su, bus.Eu, ~bus.Lb_bar,
            ~bus.Lo_bar, bus.t_state};
  endfunction

  function automatic logic [18:0] exp_vec();
    logic [11:0] a;
    logic [5:0]  ts;
    logic        h;
    int          op;
    a  = '0;
    op = int'(bus.opcode);
    case (m_step)
      0: a = 12'b0110_0000_0000;                 // Ep, Lm
      1: a = 12'b1000_0000_0000;                 // Cp
      2: a = 12'b0001_1000_0000;                 // CE, Li
      3: if (op <= 2)   a = 12'b0010_0100_0000;  // Ei, Lm
         else if (op == 14) a = 12'b0000_0001_0001; // Ea, Lo
      4: if (op == 0)   a = 12'b0001_0010_0000;  // CE, La
         else if (op == 1) a = 12'b0001_0000_0010; // CE, Lb
         else if (op == 2) a = 12'b0001_0000_1010; // CE, Lb, Su
      5: if (op == 1)   a = 12'b0000_0010_0100;  // Eu, La
         else if (op == 2) a = 12'b0000_0010_1100; // Eu, La, Su
      default: a = '0;
    endcase
    if (clr || m_halted) a = '0;
    h  = m_halted && !clr;
    ts = 6'(1 << m_step);
    return {h, a, ts};
  endfunction

  task automatic step_clk();
    @(posedge clk);
    if (clr) begin
      m_step   = 0;
      m_halted = 1'b0;
    end else if (!m_halted) begin
      if (m_step == 2 && bus.opcode == 4'hF) m_halted = 1'b1;
      m_step = (m_step + 1) % 6;
    end
    @(negedge clk);
  endtask

  // One full instruction from T1; opcode may be scrambled in T1-T2 where it is ignored.
  task automatic run_instr(input logic [3:0] op, input bit scramble, input string name);
    logic [4:0] drv;
    for (int i = 0; i < 6; i++) begin
      if (scramble && i < 2) bus.opcode = 4'($urandom);
      else bus.opcode = op;
      #1;
      n_cmp++;
      if (obs() !== exp_vec()) begin
        n_fail++;
        $display("FAIL %s step %0d: got %h required %h", name, i, obs(), exp_vec());
      end
      drv = {bus.Ep, ~bus.CE_bar, ~bus.Ei_bar, bus.Ea, bus.Eu};
      n_cmp++;
      if (!$onehot0(drv)) begin
        n_fail++;
        $display("FAIL %s bus_conflict step %0d: drivers %b required at most one", name, i, drv);
      end
      step_clk();
    end
  endtask

  task automatic test_reset();
    clr = 1'b1;
    bus.opcode = 4'($urandom);
    for (int i = 0; i < 2; i++) begin
      step_clk();
      #1;
      n_cmp++;
      if (obs() !== exp_vec()) begin
        n_fail++;
        $display("FAIL reset_hold cyc %0d: got %h required %h", i, obs(), exp_vec());
      end
    end
    clr = 1'b0;
    #1;
    n_cmp++;
    if ({bus.t_state, bus.Ep, bus.Lm_bar, bus.hlt} !== {6'b000001, 1'b1, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_first_t1: got ts=%b Ep=%b Lm_bar=%b hlt=%b required ts=000001 Ep=1 Lm_bar=0 hlt=0",
               bus.t_state, bus.Ep, bus.Lm_bar, bus.hlt);
    end
  endtask

  task automatic test_lda();
    run_instr(4'h0, 1'b0, "lda");
    #1;
    n_cmp++;
    if (bus.t_state !== 6'b000001) begin
      n_fail++;
      $display("FAIL lda_wrap: got %b required 000001", bus.t_state);
    end
  endtask

  task automatic test_add_sub();
    run_instr(4'h1, 1'b0, "add");
    run_instr(4'h2, 1'b0, "sub");
  endtask

  task automatic test_out();
    run_instr(4'hE, 1'b0, "out");
  endtask

  task automatic test_undefined();
    run_instr(4'h7, 1'b0, "undef7");
  endtask

  task automatic test_hlt();
    run_instr(4'hF, 1'b0, "hlt");
    for (int i = 0; i < 20; i++) begin
      bus.opcode = 4'($urandom);
      #1;
      n_cmp++;
      if ({bus.hlt, obs()} !== {1'b1, exp_vec()} || bus.t_state !== 6'b001000) begin
        n_fail++;
        $display("FAIL hlt_frozen cyc %0d: got %h required %h ts=001000", i, obs(), exp_vec());
      end
      step_clk();
    end
    clr = 1'b1;
    step_clk();
    clr = 1'b0;
    #1;
    n_cmp++;
    if (obs() !== exp_vec() || bus.hlt !== 1'b0 || bus.t_state !== 6'b000001) begin
      n_fail++;
      $display("FAIL hlt_clear: got %h required %h", obs(), exp_vec());
    end
  endtask

  task automatic test_clr_mid();
    bus.opcode = 4'h1;
    for (int i = 0; i < 4; i++) step_clk();
    #1;
    n_cmp++;
    if (obs() !== exp_vec() || bus.t_state !== 6'b010000) begin
      n_fail++;
      $display("FAIL clr_mid_t5: got %h required %h", obs(), exp_vec());
    end
    clr = 1'b1;
    #1;
    n_cmp++;
    if (obs() !== exp_vec()) begin
      n_fail++;
      $display("FAIL clr_mid_forced: got %h required %h", obs(), exp_vec());
    end
    step_clk();
    clr = 1'b0;
    #1;
    n_cmp++;
    if (obs() !== exp_vec() || bus.La_bar !== 1'b1 || bus.t_state !== 6'b000001) begin
      n_fail++;
      $display("FAIL clr_mid_t1: got %h required %h", obs(), exp_vec());
    end
  endtask

  task automatic test_random_stream();
    logic [3:0] op;
    for (int n = 0; n < 200; n++) begin
      op = 4'($urandom);
      run_instr(op, 1'b1, "random");
      if (m_halted) begin
        clr = 1'b1;
        step_clk();
        clr = 1'b0;
        #1;
        n_cmp++;
        if (obs() !== exp_vec()) begin
          n_fail++;
          $display("FAIL random_clr instr %0d: got %h required %h", n, obs(), exp_vec());
        end
      end
    end
  endtask

  initial begin
    n_cmp      = 0;
    n_fail     = 0;
    m_step     = 0;
    m_halted   = 1'b0;
    clr        = 1'b1;
    bus.opcode = '0;
    test_reset();
    test_lda();
    test_add_sub();
    test_out();
    test_undefined();
    test_hlt();
    test_clr_mid();
    test_random_stream();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
